// File: rtl/axis_acc_pkg.sv
// Shared types and helpers for the frame aligner / multichannel accumulator pair.
package axis_acc_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    PASS   = 2'd1,
    PAD    = 2'd2
  } align_state_t;

  // Channel counter width; CHANNELS must agree between aligner and accumulator.
  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer: one-cycle latency, full throughput, registered ready.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             w_in_fire;
  logic             w_out_free;

  // Ready depends only on the skid register, so no path from i_ready to o_ready.
  assign o_ready    = ~r_skid_valid;
  assign w_in_fire  = i_valid & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_data  <= i_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_data  = r_out_data;
  assign o_valid = r_out_valid;

endmodule

// File: rtl/axis_frame_aligner.sv
// Locks onto start-of-frame markers and emits whole CHANNELS-beat frames, zero-padding broken ones.
module axis_frame_aligner
  import axis_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  aligned,
  output logic [31:0]           frame_count,
  output logic [15:0]           drop_count
);

  localparam int unsigned   CW      = ch_width(CHANNELS);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

  align_state_t          r_state;
  align_state_t          w_state_nxt;
  logic [CW-1:0]         r_ch;
  logic [CW-1:0]         w_ch_nxt;
  logic                  w_push;
  logic                  w_push_last;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_skid_ready;
  logic                  w_drop;
  logic [DATA_WIDTH:0]   w_skid_out;
  logic                  w_out_fire;
  logic [31:0]           r_frame_count;
  logic [15:0]           r_drop_count;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= SEARCH;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ch_nxt      = r_ch;
    w_push        = 1'b0;
    w_push_last   = 1'b0;
    w_push_data   = '0;
    w_drop        = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      SEARCH: begin
        s_axis_tready = aresetn & w_skid_ready;
        if (s_axis_tvalid && s_axis_tuser && w_skid_ready) begin
          w_push      = 1'b1;
          w_push_data = s_axis_tdata;
          w_ch_nxt    = CW'(1);
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        // A marker mid-frame is held off until the frame is padded out.
        if (s_axis_tvalid && s_axis_tuser && (r_ch != '0)) begin
          w_drop      = 1'b1;
          w_state_nxt = PAD;
        end else begin
          s_axis_tready = aresetn & w_skid_ready;
          if (s_axis_tvalid && w_skid_ready) begin
            w_push      = 1'b1;
            w_push_data = s_axis_tdata;
            w_push_last = (r_ch == CH_LAST);
            w_ch_nxt    = r_ch + CW'(1);
          end
        end
      end
      PAD: begin
        if (w_skid_ready) begin
          w_push      = 1'b1;
          w_push_last = (r_ch == CH_LAST);
          w_ch_nxt    = r_ch + CW'(1);
          if (r_ch == CH_LAST) w_state_nxt = PASS;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_ch_nxt    = '0;
      end
    endcase
  end

  axis_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .i_clk   (aclk),
    .i_rstn  (aresetn),
    .i_data  ({w_push_last, w_push_data}),
    .i_valid (w_push),
    .o_ready (w_skid_ready),
    .o_data  (w_skid_out),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

  assign m_axis_tdata = w_skid_out[DATA_WIDTH-1:0];
  assign m_axis_tlast = w_skid_out[DATA_WIDTH];
  assign w_out_fire   = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_out_fire && m_axis_tlast && (r_frame_count != '1))
        r_frame_count <= r_frame_count + 32'd1;
      if (w_drop && (r_drop_count != '1))
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign aligned     = (r_state != SEARCH);
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_axis_frame_aligner.sv
// Randomized self-checking bench for axis_frame_aligner with a beat-level frame model.
module tb_axis_frame_aligner;

  localparam int DW = 16;
  localparam int CH = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tuser = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          aligned;
  logic [31:0]   frame_count;
  logic [15:0]   drop_count;

  axis_frame_aligner #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .aligned       (aligned),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level model: each offered beat maps to the output beats it must produce.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  bit    mdl_aligned = 0;
  int    mdl_ch = 0;
  int    mdl_frames = 0;
  int    mdl_drops = 0;

  function automatic void mdl_push(input logic [DW-1:0] d, input bit l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
    if (l) mdl_frames++;
  endfunction

  function automatic void mdl_offer(input logic [DW-1:0] d, input bit u);
    if (!mdl_aligned) begin
      if (u) begin
        mdl_push(d, 1'b0);
        mdl_ch = 1;
        mdl_aligned = 1;
      end
    end else begin
      if (u && mdl_ch != 0) begin
        mdl_drops++;
        while (mdl_ch != 0) begin
          mdl_push('0, mdl_ch == CH - 1);
          mdl_ch = (mdl_ch + 1) % CH;
        end
      end
      mdl_push(d, mdl_ch == CH - 1);
      mdl_ch = (mdl_ch + 1) % CH;
    end
  endfunction

  function automatic void mdl_reset();
    mdl_aligned = 0;
    mdl_ch = 0;
    mdl_frames = 0;
    mdl_drops = 0;
    exp_q.delete();
  endfunction

  int    cyc = 0;
  int    run_len = 0;
  int    max_run = 0;
  int    mr_mode = 0;
  beat_t mon_e;

  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    case (mr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'b0;
      default: m_tready = 1'($urandom_range(1));
    endcase
  end

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (aresetn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_tvalid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", m_tdata, mon_e.d);
        chk("out_last", m_tlast, mon_e.l);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    mdl_reset();
    tick(n);
    aresetn = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit u);
    int n;
    bit r;
    n = 0;
    r = 0;
    mdl_offer(d, u);
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      r = s_tready;
      @(posedge aclk);
      #1;
      n++;
    end while (!r && n < 500);
    if (!r) chk("send_timeout", r, 1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    tick(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit u;

    // Reset values
    aresetn = 1'b0;
    tick(3);
    s_tvalid = 1'b1;
    s_tuser  = 1'b1;
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", drop_count, 0);
    do_reset(2);

    // Unmarked beats are discarded until the first start-of-frame
    send(16'd1, 0);
    send(16'd2, 0);
    send(16'd3, 0);
    chk("t1_search_aligned", aligned, 0);
    send(16'd10, 1);
    send(16'd11, 0);
    send(16'd12, 0);
    send(16'd13, 0);
    drain();
    chk("t1_frames", frame_count, 1);
    chk("t1_drops", drop_count, 0);
    chk("t1_aligned", aligned, 1);

    // Contiguous frames, only the first marked, no stalls
    do_reset(2);
    max_run = 0;
    t0 = cyc;
    for (int i = 1; i <= 8; i++) send(16'(i), i == 1);
    chk("t2_no_stall_cycles", cyc - t0, 8);
    drain();
    chk("t2_valid_run", max_run, 8);
    chk("t2_frames", frame_count, 2);

    // Broken frame padded with zeros, held marker beat becomes channel 0
    do_reset(2);
    send(16'd20, 1);
    send(16'd21, 0);
    send(16'd30, 1);
    drain();
    chk("t3_frames", frame_count, 1);
    chk("t3_drops", drop_count, 1);
    chk("t3_aligned", aligned, 1);
    send(16'd31, 0);
    send(16'd32, 0);
    send(16'd33, 0);
    drain();
    chk("t3_frames_after", frame_count, 2);

    // 100 frames under random output backpressure and input gaps
    do_reset(2);
    mr_mode = 2;
    for (int f = 0; f < 100; f++) begin
      for (int c = 0; c < CH; c++) begin
        if (f == 0 && c == 0) u = 1;
        else if (c == 0)      u = 1'($urandom_range(1));
        else                  u = 0;
        send(16'($urandom), u);
        if ($urandom_range(3) == 0) tick(1);
      end
    end
    drain();
    chk("t4_frames", frame_count, 100);
    chk("t4_drops", drop_count, 0);

    // Random stream with mid-frame markers under backpressure
    do_reset(2);
    for (int i = 0; i < 200; i++) begin
      if (i == 0)           u = 1;
      else if (mdl_ch == 0) u = 1'($urandom_range(1));
      else                  u = ($urandom_range(5) == 0);
      send(16'($urandom), u);
      if ($urandom_range(4) == 0) tick(1);
    end
    drain();
    chk("t5_frames", frame_count, mdl_frames);
    chk("t5_drops", drop_count, mdl_drops);

    // Reset mid-frame discards the partial and buffered frame
    do_reset(2);
    mr_mode = 0;
    send(16'd1, 1);
    send(16'd2, 0);
    drain();
    mr_mode = 1;
    tick(1);
    send(16'd3, 0);
    tick(1);
    aresetn = 1'b0;
    mdl_reset();
    tick(1);
    aresetn = 1'b1;
    mr_mode = 0;
    tick(4);
    chk("t6_frames", frame_count, 0);
    chk("t6_drops", drop_count, 0);
    chk("t6_aligned", aligned, 0);
    chk("t6_m_tvalid", m_tvalid, 0);
    send(16'd5, 0);
    tick(2);
    chk("t6_aligned_search", aligned, 0);
    send(16'd7, 1);
    send(16'd8, 0);
    send(16'd9, 0);
    send(16'd10, 0);
    drain();
    chk("t6_frames_after", frame_count, 1);
    chk("t6_aligned_after", aligned, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_aligner.md
AXIS_FRAME_ALIGNER -- requirements
Module: axis_frame_aligner

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 Parameter CHANNELS, default 1024, samples per frame; power of two, >= 2.
REQ-003 aclk  in  1  clock; all logic rising-edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 s_axis_tdata  in  DATA_WIDTH  raw channel sample.
REQ-006 s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
REQ-007 s_axis_tuser  in  1  start-of-frame marker (channel 0).
REQ-008 m_axis_tdata  out  DATA_WIDTH  aligned sample to the accumulator.
REQ-009 m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
REQ-010 m_axis_tlast  out  1  high on channel CHANNELS-1 of every output frame.
REQ-011 aligned  out  1  high while in PASS or PAD.
REQ-012 frame_count  out  32  completed output frames, saturating.
REQ-013 drop_count  out  16  broken frames padded, saturating.

Function
REQ-014 Beat transfers only when tvalid && tready on the same edge; no combinational path from m_axis_tready to s_axis_tready.
REQ-015 States: SEARCH, PASS, PAD; channel counter ch of width log2(CHANNELS).
REQ-016 SEARCH: s_axis_tready=1; beats with tuser=0 discarded; tuser=1 beat forwarded as channel 0, ch<=1, go PASS.
REQ-017 PASS: each accepted beat forwarded, ch increments, wraps CHANNELS-1 -> 0; tlast set when ch==CHANNELS-1.
REQ-018 PASS, ch==0: tuser=0 or 1 both accepted as new frame start (contiguous frames need not be marked).
REQ-019 PASS, ch!=0, tuser=1: beat NOT accepted (s_axis_tready=0 that cycle), drop_count++, go PAD.
REQ-020 PAD: s_axis_tready=0; emit zero-data beats for channels ch..CHANNELS-1, last with tlast=1; then ch<=0, go PASS; held tuser beat becomes channel 0.
REQ-021 Output path through sub-module skid buffer; latency accepted input -> m_axis_tvalid = 1 cycle; full throughput (1 beat/cycle) when m_axis_tready held high.
REQ-022 Backpressure: when skid buffer full, s_axis_tready=0 in PASS; PAD emission stalls, ch holds.
REQ-023 frame_count increments on each output handshake with tlast=1, including padded frames; stops at 2^32-1.
REQ-024 drop_count stops at 2^16-1.
REQ-025 Output data never altered in PASS; padding value all zeros.

Reset
REQ-026 While aresetn=0: state SEARCH, ch=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, aligned=0, counts=0.
REQ-027 Reset mid-frame discards buffered and partial frame; no tlast emitted for it; first beat after reset handled by SEARCH.

Structure
REQ-028 Shared package axis_acc_pkg holds state enum typedef (SEARCH/PASS/PAD) and counter-width helper used with the accumulator.
REQ-029 One sub-module axis_skid_buffer (DATA_WIDTH+1 payload: data, last), two-entry, registered tready.
REQ-030 Block sits directly upstream of axis_multichannel_accumulator; CHANNELS must match.

Verification (bench CHANNELS=4)
REQ-031 After reset, 3 beats tuser=0 then tuser=1 beats 10,11,12,13 -> output 10,11,12,13, tlast on 13, frame_count=1, first three dropped.
REQ-032 Contiguous frames 1..8, tuser only on 1 -> two frames, tlast on 4 and 8, no stall, m_axis_tvalid high 8 consecutive cycles.
REQ-033 Frame 20,21 then tuser=1 beat 30 -> output 20,21,0,0(tlast), then 30 as channel 0; drop_count=1, frame_count=1.
REQ-034 m_axis_tready toggled 50% random during 100 frames -> no loss/duplication, tlast every 4th beat, frame_count=100.
REQ-035 aresetn low 1 cycle after channel 2 -> no tlast for partial frame, counts 0, aligned=0 until next tuser=1.
